writeback_regfile: RTL

//  Write side of the Y86-64 register file: derives dstE/dstM from the retiring instruction,

---
 rtl/y86_pkg.sv | 26 ++
 rtl/wb_dst_sel.sv | 33 +++
 rtl/writeback_regfile.sv | 89 ++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Y86-64 shared constants: instruction codes, register ids and the
// writeback state encoding.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] RSP    = 4'h4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_dst_sel.sv
// Destination register selection for the retiring instruction:
// dstE takes the ALU result, dstM takes the memory read result.
module wb_dst_sel
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    input  logic       cnd,
    output logic [3:0] dste,
    output logic [3:0] dstm
);

    always_comb begin
        dste = RNONE;
        unique case (icode)
            CMOVXX:              dste = cnd ? rB : RNONE;
            IRMOVQ, OPQ:         dste = rB;
            CALL, RET, PUSHQ,
            POPQ:                dste = RSP;
            default:             dste = RNONE;
        endcase
    end

    always_comb begin
        dstm = RNONE;
        unique case (icode)
            MRMOVQ, POPQ: dstm = rA;
            default:      dstm = RNONE;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 register file write side: commit of valE/valM, decode read
// ports, halt state machine and retired-instruction counter.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int          NREGS    = 15,
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic        stat_ok,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic        halted,
    output logic [31:0] retired
);

    logic [63:0] regs [NREGS];
    wb_state_t   state;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic        stop;
    logic        commit;
    logic        we_e;
    logic        we_m;

    wb_dst_sel u_dst_sel (
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .cnd   (cnd),
        .dste  (dste),
        .dstm  (dstm)
    );

    assign stop   = wb_valid && (icode == HALT || !stat_ok);
    assign commit = (state == RUN) && wb_valid && !stop;

    // popq %rsp targets reg4 twice; the memory value takes it
    assign we_m = commit && int'(dstm) < NREGS;
    assign we_e = commit && int'(dste) < NREGS && dste != dstm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == int'(RSP)) ? RSP_INIT : 64'h0;
        end else begin
            if (we_e) regs[dste] <= valE;
            if (we_m) regs[dstm] <= valM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            halted  <= 1'b0;
            retired <= 32'h0;
        end else begin
            unique case (state)
                RUN: begin
                    if (stop) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (wb_valid) begin
                        retired <= retired + 32'h1;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
                default: state <= HALTED;
            endcase
        end
    end

    assign valA = (int'(srcA) < NREGS) ? regs[srcA] : 64'h0;
    assign valB = (int'(srcB) < NREGS) ? regs[srcB] : 64'h0;

endmodule
